gate_exerciser: RTL and testbench

- Stimulus-and-capture stage directly upstream of the two-input gate block.
- Drives a/b through all four input combinations in order 00, 01, 10, 11.
- After each drive, waits a settle interval, then samples the five gate outputs (AND, OR, NOR, XOR, NAND) and compares them against a golden table.
- Reports the captured truth table, a per-combination fail mask and an overall pass flag, so the lab board can self-check any gate implementation.

---
 rtl/gate_lab_pkg.sv | 18 +
 rtl/gate_exerciser_settle_timer.sv | 24 ++
 rtl/gate_exerciser.sv | 136 +++++++++++++
 tb/tb_gate_exerciser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_lab_pkg.sv
// Shared types and golden data for the two-input gate lab exerciser.
// Field order inside each 5-bit combination slot is {nand,xor,nor,or,and}.
package gate_lab_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam int NUM_COMB = 4;
    localparam int AND_B    = 0;
    localparam int OR_B     = 1;
    localparam int NOR_B    = 2;
    localparam int XOR_B    = 3;
    localparam int NAND_B   = 4;

    localparam logic [19:0] EXP_TABLE = 20'h1EB54;

    function automatic logic [4:0] exp_comb(input logic [1:0] idx);
        return EXP_TABLE[5*idx +: 5];
    endfunction
endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter; zero flags the last cycle of a settle window.
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/gate_exerciser.sv
// Sweeps a/b through 00,01,10,11, captures the five gate outputs and grades them.
// Optional macro GATE_EXERCISER_FIRST_FAIL_EN adds first-failing-combination outputs.
module gate_exerciser
    import gate_lab_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    input  logic        and_in,
    input  logic        or_in,
    input  logic        nor_in,
    input  logic        xor_in,
    input  logic        nand_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [19:0] truth_table
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    ,
    output logic        first_fail_valid,
    output logic [1:0]  first_fail_idx
`endif
);
    localparam logic [1:0]       LAST_IDX   = 2'(NUM_COMB - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] idx;
    logic       t_load, t_en, t_zero;
    logic [4:0] cap;
    logic       mism;

    settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .en       (t_en),
        .load_val (SETTLE_LD),
        .zero     (t_zero)
    );

    always_comb begin
        cap          = '0;
        cap[AND_B]   = and_in;
        cap[OR_B]    = or_in;
        cap[NOR_B]   = nor_in;
        cap[XOR_B]   = xor_in;
        cap[NAND_B]  = nand_in;
    end

    // 4-state compare so an X/Z from the gate block grades as a failure
    assign mism = (cap !== exp_comb(idx));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        t_load  = 1'b0;
        t_en    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    t_load  = 1'b1;
                end
            end
            SETTLE: begin
                t_en = 1'b1;
                if (t_zero) state_n = SAMPLE;
            end
            SAMPLE: begin
                t_load  = 1'b1;
                state_n = (idx == LAST_IDX) ? DONE : SETTLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            fail_mask   <= '0;
            truth_table <= '0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx         <= '0;
                        fail_mask   <= '0;
                        truth_table <= '0;
                        pass        <= 1'b0;
                    end
                end
                SAMPLE: begin
                    truth_table[5*idx +: 5] <= cap;
                    fail_mask[idx]          <= mism;
                    if (idx == LAST_IDX)
                        pass <= (fail_mask[2:0] == 3'b000) && !mism;
                    else
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (state == SAMPLE && mism && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx;
        end
    end
`endif

    assign a    = idx[1];
    assign b    = idx[0];
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (settle 2 and settle 1) against a sweep-phase model.
module tb_gate_exerciser;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    int   fault;  // 0 good gate, 1 NAND stuck-at-0, 2 XOR replaced by OR

    logic        a [2], b [2], busy [2], done [2], pass [2];
    logic [3:0]  fm [2];
    logic [19:0] tt [2];
    logic [4:0]  g0, g1;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    logic        ffv [2];
    logic [1:0]  ffi [2];
`endif

    int passed = 0, total = 0;
    bit chk_en = 0;

    function automatic logic [4:0] gate_fn(input logic x, input logic y, input int f);
        logic n, xo;
        n  = (f == 1) ? 1'b0 : ~(x & y);
        xo = (f == 2) ? (x | y) : (x ^ y);
        return {n, xo, ~(x | y), x | y, x & y};
    endfunction

    assign g0 = gate_fn(a[0], b[0], fault);
    assign g1 = gate_fn(a[1], b[1], fault);

    gate_exerciser #(.SETTLE_CYCLES(2), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .a(a[0]), .b(b[0]),
        .and_in(g0[0]), .or_in(g0[1]), .nor_in(g0[2]), .xor_in(g0[3]), .nand_in(g0[4]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_mask(fm[0]), .truth_table(tt[0])
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
        , .first_fail_valid(ffv[0]), .first_fail_idx(ffi[0])
`endif
    );

    gate_exerciser #(.SETTLE_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .a(a[1]), .b(b[1]),
        .and_in(g1[0]), .or_in(g1[1]), .nor_in(g1[2]), .xor_in(g1[3]), .nand_in(g1[4]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_mask(fm[1]), .truth_table(tt[1])
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
        , .first_fail_valid(ffv[1]), .first_fail_idx(ffi[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Model: each sweep is 4 slots of (S+1) cycles; the last cycle of a slot samples.
    int          ph [2]   = '{0, 0};
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_pass [2] = '{1'b0, 1'b0};
    logic [1:0]  m_ab [2] = '{2'd0, 2'd0};
    logic [3:0]  m_fm [2] = '{4'd0, 4'd0};
    logic [19:0] m_tt [2] = '{20'd0, 20'd0};

    initial begin
        int s, c;
        logic [1:0] cc;
        logic [4:0] v;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                s = (k == 0) ? 2 : 1;
                if (rst) begin
                    m_busy[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                    m_ab[k] = 0; m_fm[k] = 0; m_tt[k] = 0; ph[k] = 0;
                end else if (!m_busy[k] && start) begin
                    m_busy[k] = 1; m_done[k] = 0; m_pass[k] = 0;
                    m_ab[k] = 0; m_fm[k] = 0; m_tt[k] = 0; ph[k] = 0;
                end else if (m_busy[k]) begin
                    if (ph[k] % (s + 1) == s) begin
                        c  = ph[k] / (s + 1);
                        cc = 2'(c);
                        v  = gate_fn(cc[1], cc[0], fault);
                        m_tt[k][5*c +: 5] = v;
                        m_fm[k][c] = (v !== gate_fn(cc[1], cc[0], 0));
                    end
                    ph[k]++;
                    if (ph[k] == 4 * (s + 1)) begin
                        m_busy[k] = 0; m_done[k] = 1; m_pass[k] = (m_fm[k] == 0);
                    end else begin
                        m_ab[k] = 2'(ph[k] / (s + 1));
                    end
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("u%0d_ab", k), 32'({a[k], b[k]}), 32'(m_ab[k]));
                    chk($sformatf("u%0d_busy", k), 32'(busy[k]), 32'(m_busy[k]));
                    chk($sformatf("u%0d_done", k), 32'(done[k]), 32'(m_done[k]));
                    chk($sformatf("u%0d_pass", k), 32'(pass[k]), 32'(m_pass[k]));
                    chk($sformatf("u%0d_fail_mask", k), 32'(fm[k]), 32'(m_fm[k]));
                    chk($sformatf("u%0d_truth_table", k), 32'(tt[k]), 32'(m_tt[k]));
                end
            end
        end
    end

    // Pulse start once (optionally again at negedge 'extra' while busy) and time done
    task automatic run_sweep(input int extra, output int lat0, output int lat1,
                             output logic [15:0] seq1);
        int nseq;
        lat0 = -1; lat1 = -1; seq1 = '0; nseq = 0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = (extra != 0 && n == extra);
            if (busy[1] && nseq < 8) begin
                seq1 = {seq1[13:0], a[1], b[1]};
                nseq++;
            end
            if (done[0] && lat0 < 0) lat0 = n;
            if (done[1] && lat1 < 0) lat1 = n;
            if (lat0 > 0 && lat1 > 0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int l0, l1, prev, npulse, waitn;
        logic [15:0] seq;
        logic pd;
        rst = 1'b1; start = 1'b0; fault = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_truth_table", 32'(tt[0]), 32'd0);
        chk("rst_ab", 32'({a[0], b[0]}), 32'd0);
        repeat (2) @(negedge clk);

        // good gate: latency, golden table, a/b sequence at settle 1
        run_sweep(0, l0, l1, seq);
        chk("lat_settle2", 32'(l0), 32'd13);
        chk("lat_settle1", 32'(l1), 32'd9);
        chk("good_tt", 32'(tt[0]), 32'h1EB54);
        chk("good_tt_s1", 32'(tt[1]), 32'h1EB54);
        chk("model_tt", 32'(m_tt[0]), 32'h1EB54);
        chk("good_fm", 32'(fm[0]), 32'h0);
        chk("good_pass", 32'(pass[0]), 32'd1);
        chk("ab_seq_s1", 32'(seq), 32'h05AF);
        repeat (3) @(negedge clk);

        // NAND stuck-at-0
        fault = 1;
        run_sweep(0, l0, l1, seq);
        chk("nand_fm", 32'(fm[0]), 32'h7);
        chk("nand_pass", 32'(pass[0]), 32'd0);
        chk("nand_tt", 32'(tt[0]), 32'h1A944);
        chk("model_nand_fm", 32'(m_fm[0]), 32'h7);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
        chk("nand_ff_valid", 32'(ffv[0]), 32'd1);
        chk("nand_ff_idx", 32'(ffi[0]), 32'd0);
`endif
        repeat (2) @(negedge clk);

        // XOR replaced by OR
        fault = 2;
        run_sweep(0, l0, l1, seq);
        chk("xor_fm", 32'(fm[0]), 32'h8);
        chk("xor_slot3", 32'(tt[0][19:15]), 32'b01011);
        chk("xor_pass", 32'(pass[0]), 32'd0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
        chk("xor_ff_idx", 32'(ffi[0]), 32'd3);
`endif
        repeat (2) @(negedge clk);

        // reset during idx=2 settle, then a clean sweep
        fault = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitn = 0;
        while (!(busy[0] && a[0] && !b[0]) && waitn < 30) begin
            @(negedge clk);
            waitn++;
        end
        chk("reach_idx2", 32'(waitn < 30), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        chk("abort_tt", 32'(tt[0]), 32'd0);
        chk("abort_ab", 32'({a[0], b[0]}), 32'd0);
        @(negedge clk);
        run_sweep(0, l0, l1, seq);
        chk("post_abort_pass", 32'(pass[0]), 32'd1);
        chk("post_abort_tt", 32'(tt[0]), 32'h1EB54);
        repeat (2) @(negedge clk);

        // extra start pulse while busy must not restart
        run_sweep(4, l0, l1, seq);
        chk("ignore_start_lat", 32'(l0), 32'd13);
        chk("ignore_start_lat_s1", 32'(l1), 32'd9);
        repeat (2) @(negedge clk);

        // start held: back-to-back sweeps with single-cycle done
        start = 1'b1;
        prev = -1; npulse = 0; pd = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done[0]) begin
                chk("done_one_cycle", 32'(pd), 32'd0);
                if (prev > 0) chk("sweep_period", 32'(n - prev), 32'd13);
                prev = n;
                npulse++;
            end
            pd = done[0];
        end
        start = 1'b0;
        chk("held_pulses", 32'(npulse), 32'd3);
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
